// File: rtl/pk_pkg.sv
// Shared encodings and defaults for the CDE control sequencer.
// No logic: ops, status codes, FSM states and timeout defaults.
// Backpressure: n/a.
package pk_pkg;

    typedef enum logic [1:0] {
        OP_BOOT  = 2'd0,
        OP_STORE = 2'd1,
        OP_FETCH = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_FULL      = 2'd2,
        ST_TIMEOUT   = 2'd3
    } status_t;

    typedef enum logic [4:0] {
        IDLE, B_RD, B_WR,
        S_ACC, S_ENC, S_WE, S_LD, S_FWR, S_WEN,
        F_ACC, F_SRCH, F_RD, F_DEC, F_KEY, F_ENC, F_OUT,
        CMPL
    } state_t;

    localparam int DEF_CAM_LAT   = 18;
    localparam int DEF_FLASH_TO  = 64;
    localparam int DEF_CRYPTO_TO = 255;
    localparam int TMR_W         = 8;

endpackage

// File: rtl/pk_wait_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Latency: count is valid the cycle after load.
// Backpressure: none.
module pk_wait_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/pk_cde_seq.sv
// Control sequencer for the crypto/CAM engine: BOOT, STORE and FETCH commands.
// Latency: command dependent; done pulses one cycle after the final action.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped.
module pk_cde_seq
    import pk_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int CAM_LAT    = DEF_CAM_LAT,
    parameter int FLASH_TO   = DEF_FLASH_TO,
    parameter int CRYPTO_TO  = DEF_CRYPTO_TO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH:0]   boot_count,
    output logic                  cmd_ready,
    output logic                  done,
    output logic [1:0]            status,
    output logic [ADDR_WIDTH:0]   entry_cnt,
    output logic                  flash_rd_req,
    output logic                  flash_wr_req,
    input  logic                  flash_ack,
    output logic                  cam_start,
    output logic                  write_en,
    output logic                  boot_lood,
    output logic                  start_enc,
    output logic                  start_dec,
    output logic                  flash_or_acc_reg,
    output logic                  flash_or_acc_sel,
    output logic                  flash_acc_reg,
    output logic                  flash_pass_reg,
    output logic                  pass_enc_reg,
    output logic                  plain_reg,
    output logic                  new_old_pass_sel,
    output logic                  local_master_reg,
    output logic                  local_master_sel,
    output logic                  out_reg,
    output logic [ADDR_WIDTH-1:0] write_add,
    input  logic                  match,
    input  logic                  ready_encryption,
    input  logic                  dec_done
);

    localparam int                DEPTH       = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [TMR_W-1:0]  CAM_LAT_C   = TMR_W'(CAM_LAT);
    localparam logic [TMR_W-1:0]  FLASH_TO_C  = TMR_W'(FLASH_TO);
    localparam logic [TMR_W-1:0]  CRYPTO_TO_C = TMR_W'(CRYPTO_TO);

    state_t                state, state_nxt;
    logic                  entry;
    logic [ADDR_WIDTH:0]   idx, idx_nxt, bcnt, bcnt_nxt, ent_nxt, boot_lim;
    logic [1:0]            status_nxt;
    logic                  tmr_load, tmr_exp;
    logic [TMR_W-1:0]      tmr_val;

    // One timer serves the CAM latency count and every wait timeout; it
    // reloads on each state change so every wait starts from a clean count.
    pk_wait_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    assign boot_lim = (boot_count > DEPTH_C) ? DEPTH_C : boot_count;

    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        bcnt_nxt         = bcnt;
        ent_nxt          = entry_cnt;
        status_nxt       = status;
        cmd_ready        = 1'b0;
        done             = 1'b0;
        flash_rd_req     = 1'b0;
        flash_wr_req     = 1'b0;
        cam_start        = 1'b0;
        write_en         = 1'b0;
        boot_lood        = 1'b0;
        start_enc        = 1'b0;
        start_dec        = 1'b0;
        flash_or_acc_reg = 1'b0;
        flash_or_acc_sel = 1'b0;
        flash_acc_reg    = 1'b0;
        flash_pass_reg   = 1'b0;
        pass_enc_reg     = 1'b0;
        plain_reg        = 1'b0;
        new_old_pass_sel = 1'b0;
        local_master_reg = 1'b0;
        local_master_sel = 1'b0;
        out_reg          = 1'b0;
        write_add        = '0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_BOOT: begin
                            idx_nxt  = '0;
                            bcnt_nxt = boot_lim;
                            if (boot_count == '0) begin
                                ent_nxt    = '0;
                                status_nxt = ST_OK;
                                state_nxt  = CMPL;
                            end else begin
                                state_nxt  = B_RD;
                            end
                        end
                        OP_STORE: begin
                            if (entry_cnt == DEPTH_C) begin
                                status_nxt = ST_FULL;
                                state_nxt  = CMPL;
                            end else begin
                                state_nxt  = S_ACC;
                            end
                        end
                        OP_FETCH: state_nxt = F_ACC;
                        default: begin
                            status_nxt = ST_OK;
                            state_nxt  = CMPL;
                        end
                    endcase
                end
            end
            B_RD: begin
                write_add    = idx[ADDR_WIDTH-1:0];
                flash_rd_req = 1'b1;
                // An ack landing on the expiry cycle still counts as success.
                if (flash_ack) begin
                    flash_or_acc_reg = 1'b1;
                    state_nxt        = B_WR;
                end else if (tmr_exp) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = CMPL;
                end
            end
            B_WR: begin
                write_en  = 1'b1;
                write_add = idx[ADDR_WIDTH-1:0];
                if ((idx + 1'b1) == bcnt) begin
                    ent_nxt    = bcnt;
                    status_nxt = ST_OK;
                    state_nxt  = CMPL;
                end else begin
                    idx_nxt    = idx + 1'b1;
                    state_nxt  = B_RD;
                end
            end
            S_ACC: begin
                flash_or_acc_sel = 1'b1;
                flash_or_acc_reg = 1'b1;
                plain_reg        = 1'b1;
                local_master_reg = 1'b1;
                state_nxt        = S_ENC;
            end
            S_ENC: begin
                start_enc = 1'b1;
                state_nxt = S_WE;
            end
            S_WE: begin
                if (ready_encryption) begin
                    state_nxt = S_LD;
                end else if (tmr_exp) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = CMPL;
                end
            end
            S_LD: begin
                flash_pass_reg = 1'b1;
                flash_acc_reg  = 1'b1;
                state_nxt      = S_FWR;
            end
            S_FWR: begin
                write_add    = entry_cnt[ADDR_WIDTH-1:0];
                flash_wr_req = 1'b1;
                if (flash_ack) begin
                    state_nxt = S_WEN;
                end else if (tmr_exp) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = CMPL;
                end
            end
            S_WEN: begin
                write_en   = 1'b1;
                write_add  = entry_cnt[ADDR_WIDTH-1:0];
                ent_nxt    = entry_cnt + 1'b1;
                status_nxt = ST_OK;
                state_nxt  = CMPL;
            end
            F_ACC: begin
                flash_or_acc_sel = 1'b1;
                flash_or_acc_reg = 1'b1;
                state_nxt        = F_SRCH;
            end
            F_SRCH: begin
                cam_start = entry;
                if (tmr_exp) begin
                    if (match) begin
                        state_nxt = F_RD;
                    end else begin
                        status_nxt = ST_NOT_FOUND;
                        state_nxt  = CMPL;
                    end
                end
            end
            F_RD: begin
                boot_lood    = 1'b1;
                flash_rd_req = 1'b1;
                if (flash_ack) begin
                    pass_enc_reg = 1'b1;
                    state_nxt    = F_DEC;
                end else if (tmr_exp) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = CMPL;
                end
            end
            F_DEC: begin
                start_dec = entry;
                if (dec_done) begin
                    state_nxt = F_KEY;
                end else if (tmr_exp) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = CMPL;
                end
            end
            F_KEY: begin
                new_old_pass_sel = 1'b1;
                plain_reg        = 1'b1;
                local_master_sel = 1'b1;
                local_master_reg = 1'b1;
                state_nxt        = F_ENC;
            end
            F_ENC: begin
                start_enc = entry;
                if (ready_encryption) begin
                    state_nxt = F_OUT;
                end else if (tmr_exp) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = CMPL;
                end
            end
            F_OUT: begin
                out_reg    = 1'b1;
                status_nxt = ST_OK;
                state_nxt  = CMPL;
            end
            CMPL: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        tmr_load = (state_nxt != state);
        case (state_nxt)
            F_SRCH:             tmr_val = CAM_LAT_C;
            B_RD, S_FWR, F_RD:  tmr_val = FLASH_TO_C;
            S_WE, F_DEC, F_ENC: tmr_val = CRYPTO_TO_C;
            default:            tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            entry     <= 1'b0;
            idx       <= '0;
            bcnt      <= '0;
            entry_cnt <= '0;
            status    <= ST_OK;
        end else begin
            state     <= state_nxt;
            entry     <= tmr_load;
            idx       <= idx_nxt;
            bcnt      <= bcnt_nxt;
            entry_cnt <= ent_nxt;
            status    <= status_nxt;
        end
    end

endmodule
